// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle ARM-subset controller.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC_DP,
    MEM_ADDR,
    MEM_RD,
    MEM_WR,
    MEM_WB,
    BRANCH
  } state_t;

  // IR[27:26] instruction classes
  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  // IR[31:28] condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Register-file write-data source select
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// ARM condition-code evaluator: decides whether an instruction executes
// given its condition field and the current NZCV flags.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // Combinational condition decode
  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle controller for the ARM-subset datapath: sequences fetch,
// decode, execute, memory and writeback, owns the NZCV flag register and
// guards data-memory accesses with a ready timeout.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int                 ALU_CMD_W   = 4,
  parameter logic [ALU_CMD_W-1:0] CMD_ADD   = 4'b0100,
  parameter logic [ALU_CMD_W-1:0] CMD_SUB   = 4'b0010,
  parameter int                 MEM_TIMEOUT = 16,
  parameter int                 TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic [3:0]           cond_in,
  input  logic [1:0]           op_in,
  input  logic [5:0]           nIPUBWL_in,
  input  logic [ALU_CMD_W-1:0] cmd_in,
  input  logic [3:0]           alu_flags_in,
  input  logic                 mem_ready,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src_select,
  output logic [ALU_CMD_W-1:0] alu_cmd,
  output logic                 alu_src_select,
  output logic                 datamem_addr_select,
  output logic                 datamem_RE,
  output logic                 datamem_WE,
  output logic                 regfile_WE,
  output logic [1:0]           regfile_WD_select,
  output logic [3:0]           flags_q,
  output logic                 undef_instr,
  output logic                 mem_error,
  output logic                 busy
);

  state_t           state;
  logic [TMO_W-1:0] wait_cnt;
  logic             mem_err_q;
  logic             pass;

  logic imm_bit, up_bit, load_bit;
  logic is_compare;
  logic mem_timeout;

  assign imm_bit  = nIPUBWL_in[5];
  assign up_bit   = nIPUBWL_in[3];
  assign load_bit = nIPUBWL_in[0];   // also the S bit for data-processing

  // TST/TEQ/CMP/CMN: flags only, no register result
  assign is_compare = (cmd_in[ALU_CMD_W-1 -: 2] == 2'b10);

  // Last permitted wait cycle elapsed without ready; ready in that same cycle wins
  assign mem_timeout = !mem_ready && (wait_cnt == TMO_W'(MEM_TIMEOUT - 1));

  // Remaining IR bits carry no control meaning here
  logic unused_ir_bits;
  assign unused_ir_bits = &{1'b0, nIPUBWL_in[4], nIPUBWL_in[2:1]};

  cond_check u_cond_check (
    .cond  (cond_in),
    .flags (flags_q),
    .pass  (pass)
  );

  // State sequencing, flag register, memory wait counter and error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      flags_q   <= 4'b0000;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= 1'b0;
      unique case (state)
        FETCH: begin
          if (instr_valid) state <= DECODE;
        end
        DECODE: begin
          if (!pass) begin
            state <= FETCH;
          end else begin
            unique case (op_in)
              OP_DP:   state <= EXEC_DP;
              OP_MEM:  state <= MEM_ADDR;
              OP_BR:   state <= BRANCH;
              default: state <= FETCH;
            endcase
          end
        end
        EXEC_DP: begin
          if (load_bit || is_compare) flags_q <= alu_flags_in;
          state <= FETCH;
        end
        MEM_ADDR: begin
          wait_cnt <= '0;
          state    <= load_bit ? MEM_RD : MEM_WR;
        end
        MEM_RD, MEM_WR: begin
          if (mem_ready) begin
            state <= (state == MEM_RD) ? MEM_WB : FETCH;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
            if (mem_timeout) begin
              mem_err_q <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        MEM_WB:  state <= FETCH;
        BRANCH:  state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  assign mem_error = mem_err_q;

  // Datapath control decoded from the current state and IR fields
  always_comb begin
    ir_write            = 1'b0;
    pc_write            = 1'b0;
    pc_src_select       = 1'b0;
    alu_cmd             = CMD_ADD;
    alu_src_select      = 1'b0;
    datamem_addr_select = 1'b0;
    datamem_RE          = 1'b0;
    datamem_WE          = 1'b0;
    regfile_WE          = 1'b0;
    regfile_WD_select   = WD_ALU;
    undef_instr         = 1'b0;
    busy                = (state != FETCH);
    unique case (state)
      FETCH: begin
        ir_write = instr_valid & ~reset;
      end
      DECODE: begin
        if (!pass) begin
          pc_write = 1'b1;
        end else if (op_in == OP_UNDEF) begin
          undef_instr = 1'b1;
          pc_write    = 1'b1;
        end
      end
      EXEC_DP: begin
        alu_cmd        = cmd_in;
        alu_src_select = imm_bit;
        regfile_WE     = ~is_compare;
        pc_write       = 1'b1;
      end
      MEM_ADDR: begin
        alu_cmd        = up_bit ? CMD_ADD : CMD_SUB;
        alu_src_select = imm_bit;
      end
      MEM_RD: begin
        datamem_addr_select = 1'b1;
        datamem_RE          = 1'b1;
        pc_write            = mem_timeout;
      end
      MEM_WR: begin
        datamem_addr_select = 1'b1;
        datamem_WE          = 1'b1;
        pc_write            = mem_ready | mem_timeout;
      end
      MEM_WB: begin
        regfile_WE        = 1'b1;
        regfile_WD_select = WD_MEM;
        pc_write          = 1'b1;
      end
      BRANCH: begin
        alu_cmd       = CMD_ADD;
        pc_src_select = 1'b1;
        pc_write      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
